// File: rtl/noise_sel_crossfade_pkg.sv
// noise_pkg: shared constants and FSM state type for the noise source crossfader
package noise_pkg;
    localparam int NUM_SRC = 5;
    localparam int SEL_W   = 3;
    typedef enum logic [1:0] {IDLE, FADE_OUT, SWITCH, FADE_IN} xf_state_t;
endpackage

// File: rtl/noise_sel_crossfade_gain_scale.sv
// gain_scale: tick-enabled signed sample times unsigned gain, floor-shifted back to sample width
module gain_scale #(
    parameter int WIDTH = 8,
    parameter int GW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_tick_i,
    input  logic [WIDTH-1:0] y_i,
    input  logic [GW-1:0]    gain_i,
    output logic [WIDTH-1:0] sample_o,
    output logic             sample_valid_o
);
    logic signed [WIDTH+GW:0] w_prod;
    logic        [WIDTH-1:0]  r_sample;
    logic                     r_valid;

    // gain is zero-extended so it multiplies as a non-negative signed value
    assign w_prod = $signed(y_i) * $signed({1'b0, gain_i});

    // register the scaled sample on each tick; the shift divides by the full-scale gain
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sample <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= sample_tick_i;
            if (sample_tick_i)
                r_sample <= WIDTH'(w_prod >>> (GW - 1));
        end
    end

    assign sample_o       = r_sample;
    assign sample_valid_o = r_valid;
endmodule

// File: rtl/noise_sel_crossfade.sv
// noise_sel_crossfade: click-free source switcher that fades out, swaps mux select, fades back in
module noise_sel_crossfade #(
    parameter int WIDTH      = 8,
    parameter int NUM_SRC    = noise_pkg::NUM_SRC,
    parameter int RAMP_STEPS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_tick_i,
    input  logic             req_valid_i,
    input  logic [2:0]       req_sel_i,
    output logic             req_ready_o,
    output logic             err_o,
    output logic [2:0]       mux_sel_o,
    input  logic [WIDTH-1:0] mux_y_i,
    output logic [WIDTH-1:0] sample_o,
    output logic             sample_valid_o,
    output logic             busy_o
);
    import noise_pkg::*;

    localparam int            GW    = $clog2(RAMP_STEPS) + 1;
    localparam logic [GW-1:0] G_MAX = GW'(RAMP_STEPS);
    localparam logic [GW-1:0] G_ONE = GW'(1);

    xf_state_t        r_state;
    logic [GW-1:0]    r_gain;
    logic [SEL_W-1:0] r_mux_sel;
    logic [SEL_W-1:0] r_pend;
    logic             r_err;
    logic             w_accept;
    logic             w_bad;

    assign req_ready_o = (r_state == IDLE);
    assign busy_o      = (r_state != IDLE);
    assign w_accept    = req_valid_i & req_ready_o;
    assign w_bad       = int'(req_sel_i) >= NUM_SRC;

    // control FSM: owns the gain ramp, the mux select and the request handshake
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_gain    <= G_MAX;
            r_mux_sel <= '0;
            r_pend    <= '0;
            r_err     <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_bad)
                            r_err <= 1'b1;
                        else if (req_sel_i != r_mux_sel) begin
                            r_pend  <= req_sel_i;
                            r_state <= FADE_OUT;
                        end
                    end
                end
                FADE_OUT: begin
                    if (sample_tick_i && r_gain != '0) begin
                        r_gain <= r_gain - G_ONE;
                        if (r_gain == G_ONE)
                            r_state <= SWITCH;
                    end
                end
                SWITCH: begin
                    r_mux_sel <= r_pend;
                    r_state   <= FADE_IN;
                end
                FADE_IN: begin
                    if (sample_tick_i && r_gain != G_MAX) begin
                        r_gain <= r_gain + G_ONE;
                        if (r_gain == G_MAX - G_ONE)
                            r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mux_sel_o = r_mux_sel;
    assign err_o     = r_err;

    gain_scale #(.WIDTH(WIDTH), .GW(GW)) u_scale (
        .clk            (clk),
        .rst_n          (rst_n),
        .sample_tick_i  (sample_tick_i),
        .y_i            (mux_y_i),
        .gain_i         (r_gain),
        .sample_o       (sample_o),
        .sample_valid_o (sample_valid_o)
    );
endmodule

// File: tb/tb_noise_sel_crossfade.sv
// tb_noise_sel_crossfade: directed stimulus with a sample scoreboard and direct control checks
module tb_noise_sel_crossfade;
    logic              clk = 1'b0;
    logic              rst_n;
    logic              sample_tick_i;
    logic              req_valid_i;
    logic [2:0]        req_sel_i;
    logic              req_ready_o;
    logic              err_o;
    logic [2:0]        mux_sel_o;
    logic signed [7:0] mux_y_i;
    logic signed [7:0] sample_o;
    logic              sample_valid_o;
    logic              busy_o;

    int errors = 0;
    int checks = 0;
    int exp_q[$];

    noise_sel_crossfade #(.WIDTH(8), .NUM_SRC(5), .RAMP_STEPS(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sample_tick_i  (sample_tick_i),
        .req_valid_i    (req_valid_i),
        .req_sel_i      (req_sel_i),
        .req_ready_o    (req_ready_o),
        .err_o          (err_o),
        .mux_sel_o      (mux_sel_o),
        .mux_y_i        (mux_y_i),
        .sample_o       (sample_o),
        .sample_valid_o (sample_valid_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick(input int exp);
        exp_q.push_back(exp);
        sample_tick_i = 1'b1;
        step();
        sample_tick_i = 1'b0;
    endtask

    // monitor: every valid sample must match the oldest expected value
    always @(negedge clk) begin
        if (rst_n && sample_valid_o) begin
            if (exp_q.size() == 0)
                chk("unexpected_sample_valid", 1, 0);
            else
                chk("sample", int'(sample_o), exp_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; sample_tick_i = 1'b0; req_valid_i = 1'b0; req_sel_i = 3'd0; mux_y_i = 8'sd0;
        step(); step();
        chk("rst_mux_sel", int'(mux_sel_o), 0);
        chk("rst_sample", int'(sample_o), 0);
        chk("rst_ready", int'(req_ready_o), 1);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_err", int'(err_o), 0);
        rst_n = 1'b1;
        step();
        mux_y_i = 8'sd100;
        do_tick(100);
        step(); step();
        chk("hold_sample", int'(sample_o), 100);
        chk("hold_valid_low", int'(sample_valid_o), 0);
        mux_y_i = -8'sd128;
        req_valid_i = 1'b1; req_sel_i = 3'd3;
        step();
        req_valid_i = 1'b0;
        chk("fade_busy", int'(busy_o), 1);
        chk("fade_ready", int'(req_ready_o), 0);
        do_tick(-128); do_tick(-96); do_tick(-64); do_tick(-32);
        chk("switch_sel_old", int'(mux_sel_o), 0);
        step();
        chk("switch_sel_new", int'(mux_sel_o), 3);
        do_tick(0); do_tick(-32); do_tick(-64);
        chk("fadein_busy", int'(busy_o), 1);
        do_tick(-96);
        chk("end_busy", int'(busy_o), 0);
        chk("end_ready", int'(req_ready_o), 1);
        do_tick(-128);
        mux_y_i = -8'sd1;
        req_valid_i = 1'b1; req_sel_i = 3'd0;
        step();
        req_valid_i = 1'b0;
        do_tick(-1); do_tick(-1); do_tick(-1); do_tick(-1);
        step();
        chk("sel_back_0", int'(mux_sel_o), 0);
        req_valid_i = 1'b1; req_sel_i = 3'd5;
        step();
        chk("held_not_ready", int'(req_ready_o), 0);
        chk("held_no_err", int'(err_o), 0);
        do_tick(0); do_tick(-1); do_tick(-1); do_tick(-1);
        chk("idle_ready", int'(req_ready_o), 1);
        chk("pre_accept_err", int'(err_o), 0);
        step();
        req_valid_i = 1'b0;
        chk("err_pulse", int'(err_o), 1);
        chk("err_sel_kept", int'(mux_sel_o), 0);
        chk("err_not_busy", int'(busy_o), 0);
        step();
        chk("err_pulse_end", int'(err_o), 0);
        req_valid_i = 1'b1; req_sel_i = 3'd0;
        step();
        req_valid_i = 1'b0;
        chk("noop_busy", int'(busy_o), 0);
        chk("noop_err", int'(err_o), 0);
        chk("noop_sel", int'(mux_sel_o), 0);
        do_tick(-1);
        mux_y_i = 8'sd50;
        req_valid_i = 1'b1; req_sel_i = 3'd2;
        step();
        req_valid_i = 1'b0;
        do_tick(50); do_tick(37);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst_busy", int'(busy_o), 0);
        chk("midrst_ready", int'(req_ready_o), 1);
        chk("midrst_sel", int'(mux_sel_o), 0);
        chk("midrst_sample", int'(sample_o), 0);
        step();
        do_tick(50);
        step(); step();
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
